// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared FSM state encoding and default timing/FIFO constants for the ROM loader
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEF_CYCLES     = 8;
    localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/word_fifo.sv
// word_fifo: synchronous first-word-fall-through FIFO of address/data pairs with full and empty flags
module word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // pointers carry an extra wrap bit so that full and empty can be told apart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (i_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // storage needs no reset; the pointers alone decide which entries are live
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/rom_word_serializer.sv
// rom_word_serializer: queues 32-bit bridge words and replays them as big-endian byte strobes every CYCLES clocks; checksum enabled by ROM_WORD_SERIALIZER_CHECKSUM_EN
module rom_word_serializer
    import rom_loader_pkg::*;
#(
    parameter int CYCLES         = DEF_CYCLES,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int OUT_ADDR_WIDTH = 25
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               in_addr,
    input  logic [31:0]               in_data,
    input  logic                      in_wr,
    output logic                      in_ready,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr,
    output logic [7:0]                out_data,
    output logic                      out_wr,
    output logic                      busy,
    output logic                      overflow,
    output logic [15:0]               checksum
);

    // r_cnt counts cycles since the last strobe; a word change must start LOAD one cycle early
    localparam logic [7:0] LP_LAST = 8'(CYCLES - 1);
    localparam logic [7:0] LP_PRE  = 8'(CYCLES - 2);

    state_t                    r_state;
    state_t                    w_next;
    logic [7:0]                r_cnt;
    logic [1:0]                r_byte;
    logic [31:0]               r_word;
    logic [OUT_ADDR_WIDTH-1:0] r_out_addr;
    logic [7:0]                r_out_data;
    logic                      r_overflow;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [63:0]               w_pop_data;
    logic                      w_last;
    logic                      w_go_load;
    logic                      w_gap_done;
    logic                      w_unused;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({in_addr, in_data}),
        .i_pop   (w_pop),
        .o_data  (w_pop_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push     = in_wr && !w_full;
    assign w_pop      = r_state == ST_LOAD;
    assign w_last     = r_byte == 2'd3;
    assign w_go_load  = w_last && !w_empty && r_cnt >= LP_PRE;
    assign w_gap_done = r_cnt == LP_LAST;
    assign w_unused   = &{1'b0, w_pop_data};

    // next state; after the final byte a waiting word is loaded early so strobe spacing is unbroken
    always_comb begin
        w_next = (r_state == ST_IDLE) ? (w_empty ? ST_IDLE : ST_LOAD) :
                 (r_state == ST_LOAD) ? ST_EMIT :
                 w_go_load            ? ST_LOAD :
                 (r_state == ST_EMIT) ? ST_GAP :
                 !w_gap_done          ? ST_GAP :
                 w_last               ? ST_IDLE : ST_EMIT;
    end

    // state, spacing counter, byte shifter and the held output address/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_byte     <= '0;
            r_word     <= '0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= (w_next == ST_EMIT) ? 8'd0 : r_cnt + 8'd1;
            r_overflow <= r_overflow || (in_wr && w_full);
            if (w_pop) begin
                r_word     <= w_pop_data[31:0];
                r_byte     <= 2'd0;
                r_out_data <= w_pop_data[31:24];
                r_out_addr <= {w_pop_data[32+OUT_ADDR_WIDTH-1:34], 2'b00};
            end else if (r_state == ST_GAP && w_next == ST_EMIT) begin
                r_word     <= r_word << 8;
                r_byte     <= r_byte + 2'd1;
                r_out_data <= r_word[23:16];
                r_out_addr <= {r_out_addr[OUT_ADDR_WIDTH-1:2], r_byte + 2'd1};
            end
        end
    end

`ifdef ROM_WORD_SERIALIZER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // accumulate each emitted byte on the edge that ends its strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_checksum <= '0;
        else if (r_state == ST_EMIT) r_checksum <= r_checksum + {8'd0, r_out_data};
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign in_ready = !w_full;
    assign out_addr = r_out_addr;
    assign out_data = r_out_data;
    assign out_wr   = r_state == ST_EMIT;
    assign busy     = !w_empty || r_state != ST_IDLE;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_rom_word_serializer.sv
// tb_rom_word_serializer: scoreboard bench for rom_word_serializer (default parameters)
module tb_rom_word_serializer;

    typedef struct {
        logic [24:0] a;
        logic [7:0]  d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_wr = 1'b0;
    logic        in_ready;
    logic [24:0] out_addr;
    logic [7:0]  out_data;
    logic        out_wr;
    logic        busy;
    logic        overflow;
    logic [15:0] checksum;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          q_t[$];
    ent_t        q_sb[$];
    ent_t        e;
    logic [24:0] last_a = '0;
    logic [7:0]  last_d = '0;
    logic [15:0] exp_sum = '0;

    rom_word_serializer dut (
        .clk      (clk),
        .reset    (reset),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .in_wr    (in_wr),
        .in_ready (in_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_wr   (out_wr),
        .busy     (busy),
        .overflow (overflow),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // drive one word for one cycle; called on a falling edge, returns on the next one
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic accept);
        logic [24:0] base;
        in_addr = a;
        in_data = d;
        in_wr   = 1'b1;
        if (accept) begin
            base = a[24:0] & ~25'd3;
            for (int k = 0; k < 4; k++) q_sb.push_back('{base + 25'(k), 8'(d >> (24 - 8 * k))});
        end
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int b = budget;
        while (q_t.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (q_t.size() < n) check("strobe_count", q_t.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int b = budget;
        while ((busy || q_sb.size() != 0) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (busy) check("idle_timeout", busy, 0);
        check("sb_drained", q_sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_wr"}, out_wr, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_checksum"}, checksum, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // monitor: match strobes against the scoreboard and check outputs hold between strobes
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (reset) begin
            last_a = '0;
            last_d = '0;
        end else if (out_wr) begin
            q_t.push_back(cyc);
            if (q_sb.size() == 0) check("extra_strobe", out_wr, 0);
            else begin
                e = q_sb.pop_front();
                check("addr", out_addr, e.a);
                check("data", out_data, e.d);
                exp_sum = exp_sum + {8'd0, e.d};
            end
            last_a = out_addr;
            last_d = out_data;
        end else begin
            check("hold_addr", out_addr, last_a);
            check("hold_data", out_data, last_d);
        end
    end

    initial begin
        int p;
        int s;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // single word: strobes 3 edges after the accepting cycle, then every 8
        q_t.delete();
        p = cyc;
        push(32'h0000_1004, 32'hA1B2_C3D4, 1'b1);
        wait_idle(200);
        check("single_n", q_t.size(), 4);
        for (int k = 0; k < 4 && k < q_t.size(); k++) check("single_t", q_t[k], p + 3 + 8 * k);

        // three back-to-back words: 12 strobes evenly spaced, busy drops after the final gap
        q_t.delete();
        push(32'h0000_2000, 32'h1122_3344, 1'b1);
        push(32'h0000_2004, 32'h5566_7788, 1'b1);
        push(32'h0000_2008, 32'h99AA_BBCC, 1'b1);
        wait_strobes(12, 300);
        for (int k = 1; k < q_t.size(); k++) check("burst_gap", q_t[k] - q_t[k-1], 8);
        s = (q_t.size() > 0) ? q_t[q_t.size() - 1] : cyc;
        while (cyc < s + 7) @(negedge clk);
        check("burst_busy_gap", busy, 1);
        @(negedge clk);
        check("burst_busy_end", busy, 0);
        wait_idle(50);

        // address wrap at the top of the 25-bit space
        push(32'h01FF_FFFC, 32'hDEAD_BEEF, 1'b1);
        push(32'h0200_0000, 32'hCAFE_F00D, 1'b1);
        wait_idle(300);

        // overflow: one word leaves at LOAD, so nine of ten fit
        check("ovf_before", overflow, 0);
        for (int i = 0; i < 10; i++) begin
            check("ovf_in_ready", in_ready, i < 9);
            push(32'h0000_3000 + 32'(4 * i), 32'h1000_0001 * 32'(i + 1), i < 9);
        end
        check("ovf_sticky", overflow, 1);
        wait_idle(600);
        check("ovf_after", overflow, 1);

        // mid-word reset with a second word still queued
        q_t.delete();
        push(32'h0000_4000, 32'h0102_0304, 1'b1);
        push(32'h0000_4004, 32'h0506_0708, 1'b1);
        wait_strobes(2, 100);
        reset = 1'b1;
        q_sb.delete();
        exp_sum = '0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_strobes", q_t.size(), 2);
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 1);

        // checksum over two words since reset: 0x01+0x02+0x03+0x04+4*0xFF = 0x0406
        push(32'h0000_5000, 32'h0102_0304, 1'b1);
        push(32'h0000_5004, 32'hFFFF_FFFF, 1'b1);
        wait_idle(300);
        @(negedge clk);
`ifdef ROM_WORD_SERIALIZER_CHECKSUM_EN
        check("checksum", checksum, exp_sum);
`else
        check("checksum", checksum, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
